// File: rtl/imm_gen_pipe_pkg.sv
// Shared RV32I opcode values, immediate format codes and instruction width
// for the immediate-generation pipeline.
package imm_gen_pipe_pkg;

    localparam int INST_W = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus of the immediate generator: instruction in, decoded
// immediate out, plus the illegal-instruction counter.
interface imm_gen_pipe_if
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);

    logic              in_valid_i;
    logic              in_ready_o;
    logic [INST_W-1:0] inst_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   imm_o;
    fmt_e              fmt_o;
    logic              illegal_o;
    logic [CNT_W-1:0]  err_cnt_o;

    modport master (
        output in_valid_i, inst_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, err_cnt_o
    );

    modport slave (
        input  in_valid_i, inst_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, err_cnt_o
    );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I immediate decoder: instruction word to sign-extended
// immediate, format code and illegal-opcode flag.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   imm,
    output fmt_e              fmt,
    output logic              illegal
);

    logic [31:0] imm32;

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        unique case (inst[6:0])
            OPC_OP: begin
                fmt = FMT_R;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Every format fits a signed 32-bit value, so widening is one replication.
    generate
        if (XLEN == 32) begin : g_x32
            assign imm = imm32;
        end else begin : g_wide
            assign imm = {{(XLEN-32){imm32[31]}}, imm32};
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a two-entry (output + skid) valid/ready buffer,
// flush, and a saturating illegal-instruction counter.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0]  dec_imm;
    fmt_e             dec_fmt;
    logic             dec_illegal;

    logic             out_valid_q;
    logic [XLEN-1:0]  out_imm_q;
    fmt_e             out_fmt_q;
    logic             out_illegal_q;

    logic             skid_valid_q;
    logic [XLEN-1:0]  skid_imm_q;
    fmt_e             skid_fmt_q;
    logic             skid_illegal_q;

    logic             in_ready_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic accept;
    logic take;
    logic out_free;
    logic out_load_skid;
    logic out_load_dec;
    logic skid_load;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (bus.inst_i),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // A flush discards the same-cycle input as well as the buffered entries.
    assign accept   = bus.in_valid_i && in_ready_q && !flush_i;
    assign take     = out_valid_q && bus.out_ready_i;
    assign out_free = !out_valid_q || take;

    // in_ready is low whenever the skid is full, so accept and skid drain never coincide.
    assign out_load_skid = out_free && skid_valid_q;
    assign out_load_dec  = out_free && !skid_valid_q && accept;
    assign skid_load     = !out_free && accept;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q   <= 1'b0;
            out_imm_q     <= '0;
            out_fmt_q     <= FMT_NONE;
            out_illegal_q <= 1'b0;
            skid_valid_q  <= 1'b0;
            in_ready_q    <= 1'b1;
        end else if (flush_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            if (out_load_skid) begin
                out_valid_q   <= 1'b1;
                out_imm_q     <= skid_imm_q;
                out_fmt_q     <= skid_fmt_q;
                out_illegal_q <= skid_illegal_q;
                skid_valid_q  <= 1'b0;
                in_ready_q    <= 1'b1;
            end else if (out_load_dec) begin
                out_valid_q   <= 1'b1;
                out_imm_q     <= dec_imm;
                out_fmt_q     <= dec_fmt;
                out_illegal_q <= dec_illegal;
            end else if (take) begin
                out_valid_q <= 1'b0;
            end

            if (skid_load) begin
                skid_valid_q <= 1'b1;
                in_ready_q   <= 1'b0;
            end
        end
    end

    // NOTE: skid payload has no reset; skid_valid_q alone decides whether it is meaningful.
    always_ff @(posedge clk_i) begin
        if (skid_load) begin
            skid_imm_q     <= dec_imm;
            skid_fmt_q     <= dec_fmt;
            skid_illegal_q <= dec_illegal;
        end
    end

    // Counts at acceptance, so illegal words flushed afterwards still count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (accept && dec_illegal && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.imm_o       = out_imm_q;
    assign bus.fmt_o       = out_fmt_q;
    assign bus.illegal_o   = out_illegal_q;
    assign bus.err_cnt_o   = err_cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush_i, input, 1, discards all buffered entries.
REQ-006 SHALL have port in_valid_i, input, 1, inst_i carries an instruction.
REQ-007 SHALL have port in_ready_o, output, 1, block accepts an instruction this cycle.
REQ-008 SHALL have port inst_i, input, 32, raw RV32I instruction word.
REQ-009 SHALL have port out_valid_o, output, 1, imm_o/fmt_o/illegal_o are valid.
REQ-010 SHALL have port out_ready_i, input, 1, consumer takes the output this cycle.
REQ-011 SHALL have port imm_o, output, XLEN, sign-extended immediate.
REQ-012 SHALL have port fmt_o, output, 3, format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
REQ-013 SHALL have port illegal_o, output, 1, opcode not recognised.
REQ-014 SHALL have port err_cnt_o, output, CNT_W, saturating count of accepted illegal instructions.

Function
REQ-015 SHALL decode opcode inst_i[6:0]: 0110011->R, imm 0; 0010011/0000011/1100111->I, imm inst[31:20]; 0100011->S, imm {inst[31:25],inst[11:7]}.
REQ-016 SHALL decode 1100011->B, imm {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}, a byte offset with bit 0 zero.
REQ-017 SHALL decode 0110111/0010111->U, imm {inst[31:12],12'b0}; 1101111->J, imm {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
REQ-018 SHALL sign-extend every immediate from its MSB to XLEN bits; any other opcode SHALL give imm 0, fmt NONE, illegal 1.
REQ-019 SHALL transfer input when in_valid_i && in_ready_o, and output when out_valid_o && out_ready_i.
REQ-020 SHALL present an accepted instruction on the outputs one cycle after acceptance when the output stage is empty or draining.
REQ-021 SHALL hold two entries: output register and skid register; in_ready_o SHALL be registered and equal to "skid register empty".
REQ-022 SHALL, on accept while the output is valid and not taken, store the decoded entry in the skid register; in_ready_o deasserts the next cycle.
REQ-023 SHALL, on output transfer with skid full, move skid to output and clear skid; in_ready_o reasserts the next cycle.
REQ-024 SHALL keep imm_o, fmt_o, illegal_o stable while out_valid_o && !out_ready_i.
REQ-025 SHALL, on flush_i, clear both entries (out_valid_o=0, in_ready_o=1 next cycle) and ignore any same-cycle input.
REQ-026 SHALL increment err_cnt_o on each accepted illegal instruction, including ones later flushed, and saturate at 2^CNT_W-1.
REQ-027 SHALL not change err_cnt_o on flush_i.

Reset
REQ-028 SHALL, on rst_i, set out_valid_o=0, in_ready_o=1, imm_o=0, fmt_o=7, illegal_o=0, err_cnt_o=0, skid empty.
REQ-029 SHALL give rst_i priority over flush_i and all transfers; an entry in flight at reset is lost.

Structure
REQ-030 SHALL take opcode values, fmt codes and the instruction width from the shared define header.
REQ-031 SHALL place decode in one combinational sub-module imm_decode (inst -> imm, fmt, illegal), instantiated once ahead of the buffer.

Verification
REQ-032 SHALL check 0xFFF00093 (addi x1,x0,-1), XLEN=32 -> imm 0xFFFFFFFF, fmt 1, one cycle after accept.
REQ-033 SHALL check 0xFE000EE3 (beq, offset -4), XLEN=64 -> imm 0xFFFFFFFFFFFFFFFC, fmt 3; 0x800000EF (jal) -> imm 0xFFFFFFFFFFF00000, fmt 5.
REQ-034 SHALL check back-to-back inputs with out_ready_i held 0 for 3 cycles -> first entry held, second in skid, in_ready_o=0, both delivered in order after release.
REQ-035 SHALL check flush_i asserted with skid full and same-cycle in_valid_i -> out_valid_o=0, in_ready_o=1 next cycle, input dropped.
REQ-036 SHALL check CNT_W=2 with 5 accepted 0x00000000 words -> illegal_o=1, fmt 7, err_cnt_o saturates at 3.
REQ-037 SHALL check rst_i asserted during a stall -> all outputs at reset values next cycle.
